adau_spi_arbiter: RTL and testbench

- Shares the single SPI master that drives the ADAU codec among NUM_REQ command requesters.
- Port 0 is reserved for the codec init command list. Ports 1..NUM_REQ-1 are runtime requesters (volume/mute/register tweakers).
- Serialises 32-bit codec commands, tracks each transfer to completion, and guards against a hung SPI master with a watchdog.

---
 rtl/adau_spi_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_adau_spi_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adau_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adau_spi_arbiter
// Brief    : Round-robin arbiter sharing one SPI master among NUM_REQ codec
//            command requesters (port 0 = init list), with a completion
//            watchdog. Define ADAU_ARB_STATS_EN to add transfer/abort counters.
// Revision : 1.0 - initial release
// ============================================================================
module adau_spi_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   adau_init_done,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_cmd,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [31:0]            spi_command,
    output logic                   spi_command_valid,
    input  logic                   spi_ready,
    input  logic                   spi_done,
    output logic                   busy,
    output logic [2:0]             grant_id,
`ifdef ADAU_ARB_STATS_EN
    output logic [15:0]            xfer_count,
    output logic [7:0]             timeout_count,
`endif
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] c_WDOG_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_rr_ptr;
    logic [TO_W-1:0]    r_wdog;

    logic               w_grant_any;
    logic [2:0]         w_grant_idx;
    logic [31:0]        w_grant_cmd;
    logic [NUM_REQ-1:0] w_grant_oh;
    logic [NUM_REQ-1:0] w_done_oh;
    logic               w_accept;
    logic               w_xfer_done;
    logic               w_abort;
    int                 w_dist;
    int                 w_best_dist;

    // Pick the valid port closest after rr_ptr in circular order.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = 3'd0;
        w_dist      = 0;
        w_best_dist = NUM_REQ;
        if (!adau_init_done) begin
            w_grant_any = req_valid[0];
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                w_dist = (i + 2*NUM_REQ - int'(r_rr_ptr) - 1) % NUM_REQ;
                if (req_valid[i] && (w_dist < w_best_dist)) begin
                    w_best_dist = w_dist;
                    w_grant_any = 1'b1;
                    w_grant_idx = 3'(i);
                end
            end
        end
    end

    always_comb begin
        w_grant_cmd = 32'd0;
        w_grant_oh  = '0;
        w_done_oh   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == 3'(i)) begin
                w_grant_cmd   = req_cmd[32*i +: 32];
                w_grant_oh[i] = 1'b1;
            end
            if (grant_id == 3'(i)) begin
                w_done_oh[i] = 1'b1;
            end
        end
    end

    assign w_accept    = (r_state == S_ISSUE) && spi_ready;
    assign w_xfer_done = (r_state == S_WAIT_DONE) && spi_done;
    assign w_abort     = (r_state == S_WAIT_DONE) && !spi_done && (r_wdog == c_WDOG_LAST);

    assign spi_command_valid = (r_state == S_ISSUE);
    assign busy              = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        req_done    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_any) begin
                    w_state_nxt = S_ISSUE;
                    // Reset holds the FSM in IDLE; keep the pulse quiet meanwhile.
                    req_ready   = reset ? '0 : w_grant_oh;
                end
            end
            S_ISSUE: begin
                if (spi_ready) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (spi_done) begin
                    w_state_nxt = S_IDLE;
                    req_done    = w_done_oh;
                end else if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spi_command <= 32'd0;
            grant_id    <= 3'd0;
            r_rr_ptr    <= 3'd0;
            r_wdog      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_grant_any) begin
                spi_command <= w_grant_cmd;
                grant_id    <= w_grant_idx;
                r_rr_ptr    <= w_grant_idx;
            end
            if (w_accept) begin
                r_wdog <= '0;
            end else if (r_state == S_WAIT_DONE) begin
                r_wdog <= r_wdog + TO_W'(1);
            end
            if (w_abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

`ifdef ADAU_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_count    <= 16'd0;
            timeout_count <= 8'd0;
        end else begin
            if (w_xfer_done && (xfer_count != 16'hFFFF)) begin
                xfer_count <= xfer_count + 16'd1;
            end
            if (w_abort && (timeout_count != 8'hFF)) begin
                timeout_count <= timeout_count + 8'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_adau_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adau_spi_arbiter
// Brief    : Directed self-checking bench for adau_spi_arbiter (short watchdog).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adau_spi_arbiter;

    localparam int NUM_REQ        = 3;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int TO_W           = 5;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  adau_init_done;
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_cmd;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_done;
    logic [31:0]           spi_command;
    logic                  spi_command_valid;
    logic                  spi_ready;
    logic                  spi_done;
    logic                  busy;
    logic [2:0]            grant_id;
    logic                  timeout_err;
`ifdef ADAU_ARB_STATS_EN
    logic [15:0]           xfer_count;
    logic [7:0]            timeout_count;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    adau_spi_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .adau_init_done    (adau_init_done),
        .req_valid         (req_valid),
        .req_cmd           (req_cmd),
        .req_ready         (req_ready),
        .req_done          (req_done),
        .spi_command       (spi_command),
        .spi_command_valid (spi_command_valid),
        .spi_ready         (spi_ready),
        .spi_done          (spi_done),
        .busy              (busy),
        .grant_id          (grant_id),
`ifdef ADAU_ARB_STATS_EN
        .xfer_count        (xfer_count),
        .timeout_count     (timeout_count),
`endif
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic request(input int port, input logic [31:0] cmd);
        req_cmd[32*port +: 32] = cmd;
        req_valid[port]        = 1'b1;
    endtask

    // Waits (bounded) for the grant, then checks the ISSUE cycle contents.
    task automatic grant(input int port, input logic [31:0] cmd, input string tag, output int waited);
        int n;
        n = 0;
        #1;
        while ((req_ready == '0) && (n < 50)) begin
            cyc();
            #1;
            n++;
        end
        waited = n;
        check_eq({tag, ".ready"}, 32'(req_ready), 32'(1 << port));
        cyc();
        #1;
        check_eq({tag, ".valid"}, 32'(spi_command_valid), 32'd1);
        check_eq({tag, ".cmd"}, spi_command, cmd);
        check_eq({tag, ".gid"}, 32'(grant_id), 32'(port));
    endtask

    task automatic accept(input string tag);
        spi_ready = 1'b1;
        cyc();
        spi_ready = 1'b0;
        #1;
        check_eq({tag, ".wait_busy"}, 32'(busy), 32'd1);
        check_eq({tag, ".wait_valid"}, 32'(spi_command_valid), 32'd0);
        check_eq({tag, ".wait_ready"}, 32'(req_ready), 32'd0);
    endtask

    // spi_done arrives w cycles after the accept cycle.
    task automatic finish(input int port, input int w, input string tag);
        repeat (w - 1) cyc();
        spi_done = 1'b1;
        #1;
        check_eq({tag, ".done"}, 32'(req_done), 32'(1 << port));
        cyc();
        spi_done = 1'b0;
        #1;
        check_eq({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    task automatic xfer(input int port, input logic [31:0] cmd, input int w, input logic drop,
                        input string tag, output int waited);
        request(port, cmd);
        grant(port, cmd, tag, waited);
        if (drop) req_valid[port] = 1'b0;
        accept(tag);
        finish(port, w, tag);
    endtask

    task automatic abort(input int port, input logic [31:0] cmd, input string tag);
        int waited;
        request(port, cmd);
        grant(port, cmd, tag, waited);
        req_valid[port] = 1'b0;
        accept(tag);
        repeat (TIMEOUT_CYCLES - 1) cyc();
        #1;
        check_eq({tag, ".last_busy"}, 32'(busy), 32'd1);
        check_eq({tag, ".last_done"}, 32'(req_done), 32'd0);
        cyc();
        #1;
        check_eq({tag, ".abort_idle"}, 32'(busy), 32'd0);
        check_eq({tag, ".abort_err"}, 32'(timeout_err), 32'd1);
        check_eq({tag, ".abort_done"}, 32'(req_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        int waited;
        int p;

        reset          = 1'b1;
        adau_init_done = 1'b0;
        req_valid      = '0;
        req_cmd        = '0;
        spi_ready      = 1'b0;
        spi_done       = 1'b0;
        repeat (3) cyc();

        // Reset state, with requests already pending.
        req_cmd[31:0]  = 32'h0040_0001;
        req_cmd[63:32] = 32'h0040_2300;
        req_cmd[95:64] = 32'h0040_1111;
        req_valid      = 3'b011;
        #1;
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.valid", 32'(spi_command_valid), 32'd0);
        check_eq("rst.gid", 32'(grant_id), 32'd0);
        check_eq("rst.cmd", spi_command, 32'd0);
        check_eq("rst.ready", 32'(req_ready), 32'd0);
        check_eq("rst.done", 32'(req_done), 32'd0);
        check_eq("rst.terr", 32'(timeout_err), 32'd0);
`ifdef ADAU_ARB_STATS_EN
        check_eq("rst.xfer_count", 32'(xfer_count), 32'd0);
        check_eq("rst.timeout_count", 32'(timeout_count), 32'd0);
`endif
        reset = 1'b0;

        // Init gating: only port 0 may be served until init completes.
        grant(0, 32'h0040_0001, "init0", waited);
        req_valid[0] = 1'b0;
        accept("init0");
        finish(0, 3, "init0");
        for (int k = 0; k < 3; k++) begin
            check_eq("init.holdoff_ready", 32'(req_ready), 32'd0);
            cyc();
            #1;
        end
        check_eq("init.holdoff_busy", 32'(busy), 32'd0);
        adau_init_done = 1'b1;
        grant(1, 32'h0040_2300, "init1", waited);
        req_valid[1] = 1'b0;
        accept("init1");
        finish(1, 2, "init1");

        // Round-robin from a fresh pointer with all ports valid.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            p = (i + 1) % NUM_REQ;
            xfer(p, 32'h0000_1000 + 32'(p), 3, 1'b0, $sformatf("rr%0d", i), waited);
            check_eq($sformatf("rr%0d.gap", i), 32'(waited), 32'd0);
        end
        req_valid = '0;

        // Stall in ISSUE: command must hold even if the requester changes it.
        request(2, 32'hA5A5_0002);
        grant(2, 32'hA5A5_0002, "stall", waited);
        req_valid[2]   = 1'b0;
        req_cmd[95:64] = 32'hDEAD_BEEF;
        spi_done       = 1'b1;
        #1;
        check_eq("stall.stray_done", 32'(req_done), 32'd0);
        spi_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            #1;
            check_eq("stall.valid", 32'(spi_command_valid), 32'd1);
            check_eq("stall.cmd", spi_command, 32'hA5A5_0002);
        end
        accept("stall");
        finish(2, 5, "stall");

        // spi_done on the final watchdog cycle wins over the abort.
        request(1, 32'h0040_2301);
        grant(1, 32'h0040_2301, "wd_edge", waited);
        req_valid[1] = 1'b0;
        accept("wd_edge");
        finish(1, TIMEOUT_CYCLES, "wd_edge");
        check_eq("wd_edge.terr", 32'(timeout_err), 32'd0);

        // Watchdog abort, sticky error, next request still served.
        abort(0, 32'h0040_0002, "wd_abort");
        repeat (3) cyc();
        #1;
        check_eq("wd_abort.sticky", 32'(timeout_err), 32'd1);
        xfer(2, 32'h0000_0077, 2, 1'b1, "wd_next", waited);
        check_eq("wd_next.terr", 32'(timeout_err), 32'd1);

        // Reset in WAIT_DONE: outputs clear at once, pointer returns to 0.
        request(2, 32'h0000_0088);
        grant(2, 32'h0000_0088, "rstmid", waited);
        req_valid[2] = 1'b0;
        accept("rstmid");
        cyc();
        req_cmd[31:0]  = 32'h0040_0003;
        req_cmd[95:64] = 32'h0000_0099;
        req_valid      = 3'b101;
        spi_done       = 1'b1;
        reset          = 1'b1;
        #1;
        check_eq("rstmid.busy", 32'(busy), 32'd0);
        check_eq("rstmid.valid", 32'(spi_command_valid), 32'd0);
        check_eq("rstmid.cmd", spi_command, 32'd0);
        check_eq("rstmid.gid", 32'(grant_id), 32'd0);
        check_eq("rstmid.done", 32'(req_done), 32'd0);
        check_eq("rstmid.ready", 32'(req_ready), 32'd0);
        check_eq("rstmid.terr", 32'(timeout_err), 32'd0);
        cyc();
        reset    = 1'b0;
        spi_done = 1'b0;
        grant(2, 32'h0000_0099, "rstmid_regrant", waited);
        req_valid[2] = 1'b0;
        accept("rstmid_regrant");
        finish(2, 1, "rstmid_regrant");
        grant(0, 32'h0040_0003, "rstmid_p0", waited);
        req_valid[0] = 1'b0;
        accept("rstmid_p0");
        finish(0, 1, "rstmid_p0");

        // Three more completions and one abort since the last reset.
        for (int i = 0; i < 3; i++) begin
            xfer(1, 32'h0000_0100 + 32'(i), 2, 1'b1, $sformatf("tail%0d", i), waited);
        end
        abort(2, 32'h0000_0200, "tail_abort");
`ifdef ADAU_ARB_STATS_EN
        check_eq("stats.xfer_count", 32'(xfer_count), 32'd5);
        check_eq("stats.timeout_count", 32'(timeout_count), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
